cla_addsub_pipe: RTL and testbench
==================================

Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the team's fixed 32-bit, 4-bit-group CLA adder.
- Adds generic width, a selectable number of pipeline stages, add/subtract mode, status flags and a valid/ready handshake with backpressure.
- Sits in the datapath between operand registers and consumers that may stall.

Parameters:
- WIDTH, 32, operand/result width. Must be a multiple of 4*STAGES.
- STAGES, 2, number of pipeline register stages, range 1..WIDTH/4. Each stage resolves WIDTH/STAGES bits.
- GROUP, 4, lookahead group size in bits. Fixed at 4; other values are illegal and must be rejected by an elaboration-time check.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  sum/difference.
- co  out  1  carry-out of the MSB.
- ov  out  1  signed (two's-complement) overflow.
- zero  out  1  s == 0.

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits, out_valid, s, co, ov and zero clear to 0. Any in-flight beats are discarded.
- Reset wins over every simultaneous event.
- in_ready is combinational only from out_ready and internal state. It is 0 while rst=1.
- Arithmetic:
  - add: {co,s} = a + b + ci.
  - sub: {co,s} = a + ~b + ~ci, i.e. a - b - ci.
  - In sub mode, co=1 means no borrow.
  - Results are computed modulo 2^WIDTH.
- Flags:
  - ov = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]), where b_eff = sub ? ~b : b.
  - zero = (s == 0). co does not affect zero.
- Pipeline structure:
  - Stage k (0-based) computes bit slice [(k+1)*W/S-1 : k*W/S] using 4-bit CLA groups.
  - Within a slice, group carries ripple from group to group. Inside a group, g/p lookahead is used: c1..c3 and co from g = a&b and p = a|b.
  - The carry out of each slice is registered and feeds the next stage.
  - Operand upper bits not yet consumed and completed lower sum bits travel alongside in stage registers.
  - ov and zero are formed in the last stage.
- Latency: exactly STAGES cycles from an accepted input beat (in_valid && in_ready at edge N) to out_valid=1 after edge N+STAGES-1, assuming no stall.
- Throughput: one beat per cycle when out_ready=1.
- Flow control: a single global enable, en = !out_valid || out_ready.
  - When en=1, every stage advances and in_ready=1.
  - When en=0, all stage registers and outputs hold and in_ready=0.
  - Bubbles (invalid stages) advance like data. They are not compressed.
- Outputs are stable while out_valid && !out_ready.
- s/co/ov/zero hold their last values when out_valid=0. Consumers must ignore them.
- sub and ci are sampled with the beat; changing them mid-flight does not affect beats already accepted.
- in_valid=0 with en=1 inserts a bubble.

Test Plan:
- Default parameters; a=32'hFFFF_FFFF, b=1, ci=0, sub=0, out_ready=1:
  - Output after 2 cycles: s=0, co=1, zero=1, ov=0.
- a=32'h7FFF_FFFF, b=1, add:
  - s=32'h8000_0000, co=0, ov=1.
- Subtract a=5, b=7, ci=0:
  - s=32'hFFFF_FFFE, co=0 (borrow), ov=0.
- Subtract a=10, b=3, ci=1:
  - s=6, co=1.
- Backpressure with back-to-back beats (1+1, 2+2, 3+3, 4+4); out_ready held 0 for 3 cycles once out_valid rises:
  - in_ready drops to 0 while stalled.
  - s=2 is held stable throughout the stall.
  - After release, results 2, 4, 6, 8 appear in order on consecutive cycles.
  - No beat is lost or duplicated.
- rst asserted for one cycle while 2 beats are in flight:
  - Next cycle: out_valid=0, s=0, co=ov=zero=0.
  - The in-flight beats are never output.
  - A new beat 3+4 yields s=7 after 2 cycles.
- Parameter sweep WIDTH=16, STAGES=1/2/4; 1000 random beats with random in_valid/out_ready against a reference model:
  - Results match the model, including carry across every slice and group boundary (e.g. a=16'h0FFF, b=1 -> s=16'h1000).
  - Latency is exactly STAGES cycles.

Source files
------------

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: pipelined carry-lookahead adder/subtractor.
// Each register stage resolves WIDTH/STAGES result bits with 4-bit lookahead
// groups, and slice carries pass from one stage to the next. The operands are
// normalised at the input. Subtraction becomes a + ~b + ~ci, so every stage
// only ever performs an add. A single global enable stalls the whole pipe
// when the consumer holds off.
module cla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov,
  output logic             zero
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int NGRP  = SLICE / GROUP;

  // Reject configurations the slice/group arithmetic cannot represent.
  if (GROUP != 4) begin : g_bad_group
    $error("cla_addsub_pipe: GROUP must be 4");
  end
  if (STAGES < 1 || STAGES > WIDTH / 4) begin : g_bad_stages
    $error("cla_addsub_pipe: STAGES must be in 1..WIDTH/4");
  end
  if (WIDTH % (4 * STAGES) != 0) begin : g_bad_width
    $error("cla_addsub_pipe: WIDTH must be a multiple of 4*STAGES");
  end

  // 4-bit lookahead group: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] cv;
    g = x & y;
    p = x | y;
    cv[0] = c;
    cv[1] = g[0] | (p[0] & c);
    cv[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cv[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    cv[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c);
    return {cv[4], x ^ y ^ cv[3:0]};
  endfunction

  // Each stage register holds the operands, the partial sum and the slice carry.
  // Operand bits below the slice are dead after use and are trimmed by synthesis.
  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0][WIDTH-1:0] opa_q, opa_d;
  logic [STAGES-1:0][WIDTH-1:0] opb_q, opb_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
  logic [STAGES-1:0]            cy_q, cy_d;
  logic                         ov_q, ov_d;
  logic                         zero_q, zero_d;

  logic             en;
  logic             src_vld;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_sum;
  logic             src_cy;
  logic [WIDTH-1:0] res_sum;
  logic             carry;
  logic [4:0]       grp;
  int               prev;
  int               lo;

  assign en        = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = !rst && en;
  assign out_valid = vld_q[STAGES-1];
  assign s         = sum_q[STAGES-1];
  assign co        = cy_q[STAGES-1];
  assign ov        = ov_q;
  assign zero      = zero_q;

  // Advance every stage by one slice when enabled; hold everything otherwise.
  always_comb begin
    vld_d   = vld_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    ov_d    = ov_q;
    zero_d  = zero_q;
    src_vld = 1'b0;
    src_a   = '0;
    src_b   = '0;
    src_sum = '0;
    src_cy  = 1'b0;
    res_sum = '0;
    carry   = 1'b0;
    grp     = '0;
    prev    = 0;
    lo      = 0;
    if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        prev = (k == 0) ? 0 : k - 1;
        if (k == 0) begin
          src_vld = in_valid;
          src_a   = a;
          src_b   = sub ? ~b : b;
          src_sum = '0;
          src_cy  = sub ? ~ci : ci;
        end else begin
          src_vld = vld_q[prev];
          src_a   = opa_q[prev];
          src_b   = opb_q[prev];
          src_sum = sum_q[prev];
          src_cy  = cy_q[prev];
        end
        carry   = src_cy;
        res_sum = src_sum;
        for (int g = 0; g < NGRP; g++) begin
          lo = k * SLICE + g * GROUP;
          grp = cla4(src_a[lo +: 4], src_b[lo +: 4], carry);
          res_sum[lo +: 4] = grp[3:0];
          carry = grp[4];
        end
        vld_d[k] = src_vld;
        opa_d[k] = src_a;
        opb_d[k] = src_b;
        sum_d[k] = res_sum;
        cy_d[k]  = carry;
      end
      ov_d   = (opa_d[STAGES-1][WIDTH-1] == opb_d[STAGES-1][WIDTH-1]) &&
               (sum_d[STAGES-1][WIDTH-1] != opa_d[STAGES-1][WIDTH-1]);
      zero_d = (sum_d[STAGES-1] == '0);
    end
  end

  // Pipeline registers; reset discards in-flight beats and clears the flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      sum_q  <= '0;
      cy_q   <= '0;
      ov_q   <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      sum_q  <= sum_d;
      cy_q   <= cy_d;
      ov_q   <= ov_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Testbench for cla_addsub_pipe.
// The default 32-bit / 2-stage instance is checked with table vectors and
// hand-written sequences for backpressure and reset. Three 16-bit instances
// (1, 2 and 4 stages) are checked against an arithmetic reference model
// with random traffic.
module tb_cla_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, s;
  logic        ci, sub, co, ov, zero;

  cla_addsub_pipe #(.WIDTH(32), .STAGES(2), .GROUP(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ov(ov), .zero(zero)
  );

  logic            r_in_valid, r_out_ready, rci, rsub;
  logic [15:0]     ra, rb;
  logic [2:0]      sw_rdy, sw_vld, sw_co, sw_ovf, sw_z;
  logic [2:0][15:0] sw_s;
  int              stg [3] = '{1, 2, 4};

  cla_addsub_pipe #(.WIDTH(16), .STAGES(1), .GROUP(4)) u_w16_s1 (
    .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(sw_rdy[0]),
    .a(ra), .b(rb), .ci(rci), .sub(rsub), .out_valid(sw_vld[0]), .out_ready(r_out_ready),
    .s(sw_s[0]), .co(sw_co[0]), .ov(sw_ovf[0]), .zero(sw_z[0])
  );
  cla_addsub_pipe #(.WIDTH(16), .STAGES(2), .GROUP(4)) u_w16_s2 (
    .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(sw_rdy[1]),
    .a(ra), .b(rb), .ci(rci), .sub(rsub), .out_valid(sw_vld[1]), .out_ready(r_out_ready),
    .s(sw_s[1]), .co(sw_co[1]), .ov(sw_ovf[1]), .zero(sw_z[1])
  );
  cla_addsub_pipe #(.WIDTH(16), .STAGES(4), .GROUP(4)) u_w16_s4 (
    .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(sw_rdy[2]),
    .a(ra), .b(rb), .ci(rci), .sub(rsub), .out_valid(sw_vld[2]), .out_ready(r_out_ready),
    .s(sw_s[2]), .co(sw_co[2]), .ov(sw_ovf[2]), .zero(sw_z[2])
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        zero;
  } vec_t;

  vec_t        vecs [10];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          consumed [3];
  logic [18:0] sb [3][$];
  int          lat_q [3][$];

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain modular and signed-integer arithmetic, {co, ov, zero, s}.
  function automatic logic [18:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic do_sub);
    int          sx, sy, rs;
    logic [16:0] full;
    logic        cout, ovf;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (do_sub) begin
      full = {1'b0, x} - {1'b0, y} - {16'b0, c};
      cout = ~full[16];
      rs   = sx - sy - int'(c);
    end else begin
      full = {1'b0, x} + {1'b0, y} + {16'b0, c};
      cout = full[16];
      rs   = sx + sy + int'(c);
    end
    ovf = (rs > 32767) || (rs < -32768);
    return {cout, ovf, (full[15:0] == 16'd0), full[15:0]};
  endfunction

  // One beat on the 32-bit instance; the result must appear exactly two cycles later.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    a = v.a; b = v.b; ci = v.ci; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 checkOutput($sformatf("vec%0d in_ready", idx), 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; sub = ~v.sub; ci = ~v.ci;
    checkOutput($sformatf("vec%0d early valid", idx), 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput($sformatf("vec%0d out_valid", idx), 64'(out_valid), 64'd1);
    checkOutput($sformatf("vec%0d s", idx), 64'(s), 64'(v.s));
    checkOutput($sformatf("vec%0d co", idx), 64'(co), 64'(v.co));
    checkOutput($sformatf("vec%0d ov", idx), 64'(ov), 64'(v.ov));
    checkOutput($sformatf("vec%0d zero", idx), 64'(zero), 64'(v.zero));
  endtask

  // One cycle of random traffic on the 16-bit instances, scored against the model.
  task automatic randomCycle(input bit stall_mode, input bit feed, input bit lat_mode);
    logic [18:0] exp;
    @(negedge clk);
    cyc++;
    r_out_ready = stall_mode ? ($urandom_range(3) != 0) : 1'b1;
    r_in_valid  = feed ? ($urandom_range(3) != 0) : 1'b0;
    if ($urandom_range(3) == 0) begin
      ra = 16'((17'd1 << $urandom_range(16, 1)) - 17'd1);
      rb = 16'd1;
    end else begin
      ra = 16'($urandom);
      rb = 16'($urandom);
    end
    rci  = 1'($urandom);
    rsub = 1'($urandom);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (sw_vld[i] && r_out_ready) begin
        if (sb[i].size() == 0) begin
          checkOutput($sformatf("w16 s%0d spurious beat", stg[i]), 64'd1, 64'd0);
        end else begin
          exp = sb[i].pop_front();
          checkOutput($sformatf("w16 s%0d result", stg[i]),
                      64'({sw_co[i], sw_ovf[i], sw_z[i], sw_s[i]}), 64'(exp));
          consumed[i]++;
          if (lat_mode && lat_q[i].size() != 0)
            checkOutput($sformatf("w16 s%0d latency", stg[i]), 64'(cyc), 64'(lat_q[i].pop_front()));
        end
      end
      if (r_in_valid && sw_rdy[i]) begin
        sb[i].push_back(model16(ra, rb, rci, rsub));
        if (lat_mode) lat_q[i].push_back(cyc + stg[i]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent, got, stall, cycles, minc;

    vecs[0] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'd10,        32'd3,         1'b1, 1'b1, 32'd6,         1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'd1,         1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'd0,         32'd0,         1'b1, 1'b0, 32'd1,         1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'd5,         32'd5,         1'b0, 1'b1, 32'd0,         1'b1, 1'b0, 1'b1};
    vecs[7] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0001_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0,         1'b1, 1'b1, 1'b1};
    vecs[9] = '{32'd3,         32'd4,         1'b0, 1'b0, 32'd7,         1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    r_in_valid = 1'b0; r_out_ready = 1'b1; ra = '0; rb = '0; rci = 1'b0; rsub = 1'b0;
    for (int i = 0; i < 3; i++) consumed[i] = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset s", 64'(s), 64'd0);
    checkOutput("reset flags", 64'({co, ov, zero}), 64'd0);
    rst = 1'b0;

    // Table-driven single beats.
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // Backpressure: four back-to-back beats, consumer stalls for three cycles.
    sent = 0; got = 0; stall = 0; cycles = 0;
    while (got < 4 && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (out_valid && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = (sent < 4); a = 32'(sent + 1); b = 32'(sent + 1); ci = 1'b0; sub = 1'b0;
      #1;
      if (!out_ready) begin
        checkOutput("bp in_ready", 64'(in_ready), 64'd0);
        checkOutput("bp held valid", 64'(out_valid), 64'd1);
        checkOutput("bp held s", 64'(s), 64'd2);
      end
      if (stall == 3 && out_ready && got < 4)
        checkOutput("bp consecutive", 64'(out_valid), 64'd1);
      if (out_valid && out_ready) begin
        checkOutput("bp order", 64'(s), 64'(2 * (got + 1)));
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    if (got < 4) checkOutput("bp timeout", 64'(got), 64'd4);
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 checkOutput("bp no duplicate", 64'(out_valid), 64'd0);
    end

    // Reset with two beats in flight.
    @(negedge clk);
    in_valid = 1'b1; a = 32'd9; b = 32'd9; out_ready = 1'b1;
    @(negedge clk);
    a = 32'd10; b = 32'd10;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1 checkOutput("rst in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    checkOutput("post-rst out_valid", 64'(out_valid), 64'd0);
    checkOutput("post-rst s", 64'(s), 64'd0);
    checkOutput("post-rst flags", 64'({co, ov, zero}), 64'd0);
    repeat (4) begin
      @(negedge clk);
      #1 checkOutput("flushed beat", 64'(out_valid), 64'd0);
    end
    applyStimulus(vecs[9], 9);

    // Random traffic with backpressure on the 16-bit instances.
    minc = 0;
    while (minc < 1000 && cyc < 20000) begin
      randomCycle(1'b1, 1'b1, 1'b0);
      minc = consumed[0];
      for (int i = 1; i < 3; i++) if (consumed[i] < minc) minc = consumed[i];
    end
    if (minc < 1000) checkOutput("random timeout", 64'(minc), 64'd1000);
    repeat (10) randomCycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("w16 s%0d drained", stg[i]), 64'(sb[i].size()), 64'd0);

    // Exact latency with the consumer always ready.
    repeat (200) randomCycle(1'b0, 1'b1, 1'b1);
    repeat (10) randomCycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("w16 s%0d lat drained", stg[i]), 64'(sb[i].size()), 64'd0);
      checkOutput($sformatf("w16 s%0d lat queue", stg[i]), 64'(lat_q[i].size()), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
